// File: rtl/q_skew_monitor_if.sv
// Observed q1/q2/q3 lines plus the skew measurement results of q_skew_monitor.
// The master side drives the observed lines; the slave side is the monitor.
interface q_skew_monitor_if #(
   parameter int CNT_W = 8
);
   logic             q1;
   logic             q2;
   logic             q3;
   logic [CNT_W-1:0] skew2;
   logic [CNT_W-1:0] skew3;
   logic             meas_valid;
   logic             timeout_err;
   logic             overrun;
   logic             busy;

   modport master (
      output q1, q2, q3,
      input  skew2, skew3, meas_valid, timeout_err, overrun, busy
   );

   modport slave (
      input  q1, q2, q3,
      output skew2, skew3, meas_valid, timeout_err, overrun, busy
   );
endinterface

// File: rtl/q_skew_monitor.sv
// Measures cycles from each q1 edge until q2 and q3 match it; 2-cycle synchronizer on every input,
// results one cycle after the last match; no backpressure, pulses are single-cycle and unqualified.
module q_skew_monitor #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 200
) (
   input  logic            clk,
   input  logic            rstn,
   q_skew_monitor_if.slave mon
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MEAS   = 2'd1,
      REPORT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state, state_n;
   logic [2:0]       sync_a, sync_b;
   logic             q1s, q2s, q3s, q1p;
   logic             q1_edge;
   logic             target, target_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             got2, got2_n, got3, got3_n;
   logic [CNT_W-1:0] sk2, sk2_n, sk3, sk3_n;
   logic [CNT_W-1:0] skew2, skew2_n, skew3, skew3_n;
   logic             meas_valid, meas_valid_n;
   logic             timeout_err, timeout_err_n;
   logic             overrun, overrun_n;

   assign {q3s, q2s, q1s} = sync_b;
   assign q1_edge         = (q1s != q1p);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_a <= 3'b000;
         sync_b <= 3'b000;
         q1p    <= 1'b0;
      end else begin
         sync_a <= {mon.q3, mon.q2, mon.q1};
         sync_b <= sync_a;
         q1p    <= sync_b[0];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         target      <= 1'b0;
         cnt         <= '0;
         got2        <= 1'b0;
         got3        <= 1'b0;
         sk2         <= '0;
         sk3         <= '0;
         skew2       <= '0;
         skew3       <= '0;
         meas_valid  <= 1'b0;
         timeout_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_n;
         target      <= target_n;
         cnt         <= cnt_n;
         got2        <= got2_n;
         got3        <= got3_n;
         sk2         <= sk2_n;
         sk3         <= sk3_n;
         skew2       <= skew2_n;
         skew3       <= skew3_n;
         meas_valid  <= meas_valid_n;
         timeout_err <= timeout_err_n;
         overrun     <= overrun_n;
      end
   end

   always_comb begin
      state_n       = state;
      target_n      = target;
      cnt_n         = cnt;
      got2_n        = got2;
      got3_n        = got3;
      sk2_n         = sk2;
      sk3_n         = sk3;
      skew2_n       = skew2;
      skew3_n       = skew3;
      meas_valid_n  = 1'b0;
      timeout_err_n = 1'b0;
      overrun_n     = 1'b0;

      if (q1_edge) begin
         // A new q1 value always restarts; only an edge caught mid-measurement is an overrun.
         overrun_n = (state == MEAS);
         target_n  = q1s;
         cnt_n     = CNT_ONE;
         got2_n    = (q2s == q1s);
         got3_n    = (q3s == q1s);
         if (got2_n) sk2_n = '0;
         if (got3_n) sk3_n = '0;
         state_n = (got2_n && got3_n) ? REPORT : MEAS;
      end else begin
         case (state)
            MEAS: begin
               if (!got2 && (q2s == target)) begin
                  got2_n = 1'b1;
                  sk2_n  = cnt;
               end
               if (!got3 && (q3s == target)) begin
                  got3_n = 1'b1;
                  sk3_n  = cnt;
               end
               if (got2_n && got3_n) begin
                  state_n = REPORT;
               end else if (cnt == TO_CNT) begin
                  timeout_err_n = 1'b1;
                  skew2_n       = got2_n ? sk2_n : '1;
                  skew3_n       = got3_n ? sk3_n : '1;
                  state_n       = IDLE;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end

      // Results are registered on entry to REPORT so meas_valid and skews appear together.
      if (state_n == REPORT) begin
         meas_valid_n = 1'b1;
         skew2_n      = sk2_n;
         skew3_n      = sk3_n;
      end
   end

   assign mon.skew2       = skew2;
   assign mon.skew3       = skew3;
   assign mon.meas_valid  = meas_valid;
   assign mon.timeout_err = timeout_err;
   assign mon.overrun     = overrun;
   assign mon.busy        = (state == MEAS);
endmodule

// File: tb/tb_q_skew_monitor.sv
// Self-checking bench for q_skew_monitor: event-level reference model compared every cycle,
// plus directed scenarios with hand-computed latencies and skews.
module tb_q_skew_monitor;
   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 200;
   localparam bit [7:0] ALL1 = 8'hFF;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   q_skew_monitor_if #(.CNT_W(CNT_W)) bus ();

   q_skew_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk  (clk),
      .rstn (rstn),
      .mon  (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Reference model: inputs reach the measurement two cycles late; skew = cycles since the edge.
   bit [2:0] m_fa, m_fb;
   bit       m_p1;
   bit       m_active;
   int       m_cyc, m_e, m_k2, m_k3;
   bit       m_tgt;
   bit [7:0] e_sk2, e_sk3;
   bit       e_mv, e_to, e_ov, e_busy;

   initial forever begin
      bit s1, s2, s3, q1_edge;
      @(posedge clk or negedge rstn);
      if (!rstn) begin
         m_fa = 3'b000; m_fb = 3'b000; m_p1 = 1'b0;
         m_active = 1'b0; m_cyc = 0;
         e_sk2 = 8'h00; e_sk3 = 8'h00;
         e_mv = 1'b0; e_to = 1'b0; e_ov = 1'b0; e_busy = 1'b0;
      end else begin
         s1 = m_fb[0]; s2 = m_fb[1]; s3 = m_fb[2];
         q1_edge = (s1 != m_p1);
         e_mv = 1'b0; e_to = 1'b0; e_ov = 1'b0;
         if (q1_edge) begin
            e_ov     = m_active;
            m_active = 1'b1;
            m_e      = m_cyc;
            m_tgt    = s1;
            m_k2     = (s2 == s1) ? 0 : -1;
            m_k3     = (s3 == s1) ? 0 : -1;
         end else if (m_active) begin
            if (m_k2 < 0 && s2 == m_tgt) m_k2 = m_cyc - m_e;
            if (m_k3 < 0 && s3 == m_tgt) m_k3 = m_cyc - m_e;
         end
         if (m_active && m_k2 >= 0 && m_k3 >= 0) begin
            e_mv = 1'b1; e_sk2 = 8'(m_k2); e_sk3 = 8'(m_k3);
            m_active = 1'b0;
         end else if (m_active && !q1_edge && (m_cyc - m_e) == TIMEOUT) begin
            e_to  = 1'b1;
            e_sk2 = (m_k2 >= 0) ? 8'(m_k2) : ALL1;
            e_sk3 = (m_k3 >= 0) ? 8'(m_k3) : ALL1;
            m_active = 1'b0;
         end
         e_busy = m_active;
         m_p1 = s1;
         m_fb = m_fa;
         m_fa = {bus.q3, bus.q2, bus.q1};
         m_cyc++;
      end
   end

   initial forever begin
      @(negedge clk);
      check("cycle outputs",
            longint'({bus.skew2, bus.skew3, bus.meas_valid, bus.timeout_err, bus.overrun, bus.busy}),
            longint'({e_sk2, e_sk3, e_mv, e_to, e_ov, e_busy}));
   end

   // Event log of DUT pulses, used by the directed scenarios.
   int       mv_cnt = 0, to_cnt = 0, ov_cnt = 0;
   int       mv_cyc = 0, to_cyc = 0, ov_cyc = 0;
   bit [7:0] mv_s2, mv_s3, to_s2, to_s3;

   initial forever begin
      @(negedge clk);
      if (bus.meas_valid === 1'b1) begin
         mv_cnt++; mv_cyc = cyc; mv_s2 = bus.skew2; mv_s3 = bus.skew3;
      end
      if (bus.timeout_err === 1'b1) begin
         to_cnt++; to_cyc = cyc; to_s2 = bus.skew2; to_s3 = bus.skew3;
      end
      if (bus.overrun === 1'b1) begin
         ov_cnt++; ov_cyc = cyc;
      end
   end

   initial begin
      int c0, m0, t0, o0;
      bit fast;
      bus.q1 = 1'($urandom); bus.q2 = 1'($urandom); bus.q3 = 1'($urandom);
      repeat (3) begin
         tick(1);
         bus.q1 = 1'($urandom); bus.q2 = 1'($urandom); bus.q3 = 1'($urandom);
      end
      check("reset outputs",
            longint'({bus.skew2, bus.skew3, bus.meas_valid, bus.timeout_err, bus.overrun, bus.busy}), 0);
      rstn = 1'b1;
      tick(1);
      bus.q1 = 1'b0; bus.q2 = 1'b0; bus.q3 = 1'b0;
      tick(12);

      // Nominal: q2 three cycles behind q1, q3 five.
      m0 = mv_cnt; c0 = cyc;
      bus.q1 = 1'b1;
      tick(3); bus.q2 = 1'b1;
      tick(2); bus.q3 = 1'b1;
      tick(10);
      check("nominal mv count", mv_cnt - m0, 1);
      check("nominal latency", mv_cyc - c0, 8);
      check("nominal skew2", mv_s2, 3);
      check("nominal skew3", mv_s3, 5);

      // Zero skew: all three change together.
      m0 = mv_cnt; c0 = cyc;
      bus.q1 = 1'b0; bus.q2 = 1'b0; bus.q3 = 1'b0;
      tick(8);
      check("zero mv count", mv_cnt - m0, 1);
      check("zero latency", mv_cyc - c0, 3);
      check("zero skews", longint'({mv_s2, mv_s3}), 0);

      // Timeout: q3 never follows.
      m0 = mv_cnt; t0 = to_cnt; c0 = cyc;
      bus.q1 = 1'b1;
      tick(4); bus.q2 = 1'b1;
      tick(TIMEOUT + 10);
      check("timeout count", to_cnt - t0, 1);
      check("timeout latency", to_cyc - c0, TIMEOUT + 3);
      check("timeout skew2", to_s2, 4);
      check("timeout skew3", to_s3, 8'hFF);
      check("timeout no mv", mv_cnt - m0, 0);

      // Overrun: q1 returns to its old value before the others follow.
      bus.q3 = 1'b1;
      tick(5);
      m0 = mv_cnt; o0 = ov_cnt; c0 = cyc;
      bus.q1 = 1'b0;
      tick(2); bus.q1 = 1'b1;
      tick(8);
      check("overrun count", ov_cnt - o0, 1);
      check("overrun latency", ov_cyc - c0, 5);
      check("overrun remeasure count", mv_cnt - m0, 1);
      check("overrun remeasure latency", mv_cyc - c0, 5);
      check("overrun remeasure skews", longint'({mv_s2, mv_s3}), 0);

      // Asynchronous reset while measuring.
      bus.q1 = 1'b0;
      tick(5);
      check("busy before reset", bus.busy, 1);
      rstn = 1'b0;
      #1;
      check("async reset outputs",
            longint'({bus.skew2, bus.skew3, bus.meas_valid, bus.timeout_err, bus.overrun, bus.busy}), 0);
      tick(3);
      rstn = 1'b1;
      m0 = mv_cnt; t0 = to_cnt;
      tick(20);
      check("no stale mv", mv_cnt - m0, 0);
      check("no stale timeout", to_cnt - t0, 0);
      check("idle after reset", bus.busy, 0);

      // Randomized traffic: slow q1 for full measurements, a fast burst for overruns.
      for (int i = 0; i < 3000; i++) begin
         fast = (i >= 1000 && i < 1500);
         tick(1);
         if ($urandom_range(0, fast ? 2 : 39) == 0) bus.q1 = ~bus.q1;
         if ($urandom_range(0, 4) == 0) bus.q2 = ~bus.q2;
         if ($urandom_range(0, 6) == 0) bus.q3 = ~bus.q3;
      end
      tick(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
